// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry
// Keypad front end: synchronises ten asynchronous key lines, detects per-key
// rising edges, encodes a single clean press to BCD and shifts it into a
// four-digit sliding entry window.
//
// Ports
//   clk            system clock, all updates on rising edge
//   rst            asynchronous active-low reset
//   Input0..Input9 key n pressed when high (asynchronous, no debounce)
//   p10            most recently entered digit
//   p11            second most recent digit
//   p12            third most recent digit
//   p13            oldest (fourth most recent) digit
module keypad_digit_entry #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Input0,
   input  logic       Input1,
   input  logic       Input2,
   input  logic       Input3,
   input  logic       Input4,
   input  logic       Input5,
   input  logic       Input6,
   input  logic       Input7,
   input  logic       Input8,
   input  logic       Input9,
   output logic [3:0] p10,
   output logic [3:0] p11,
   output logic [3:0] p12,
   output logic [3:0] p13
);

   localparam int unsigned NKEYS   = 10;
   localparam int unsigned DIGIT_W = 4;

   logic [NKEYS-1:0]   keys_c;
   logic [NKEYS-1:0]   sync_q [SYNC_STAGES];
   logic [NKEYS-1:0]   prev_q;
   logic [NKEYS-1:0]   sync_s_c;
   logic [NKEYS-1:0]   rise_c;
   logic               valid_c;
   logic [DIGIT_W-1:0] digit_c;

   assign keys_c = {Input9, Input8, Input7, Input6, Input5,
                    Input4, Input3, Input2, Input1, Input0};

   // Multi-stage synchroniser per key line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= keys_c;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_s_c = sync_q[SYNC_STAGES-1];

   // Previous synchronised sample for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= '0;
      end else begin
         prev_q <= sync_s_c;
      end
   end

   assign rise_c = sync_s_c & ~prev_q;

   // A press counts only when it is the sole new edge and no other key is down
   assign valid_c = $onehot(rise_c) && $onehot(sync_s_c);

   // One-hot to BCD index
   always_comb begin
      digit_c = '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
         if (rise_c[i]) begin
            digit_c = DIGIT_W'(i);
         end
      end
   end

   // Sliding four-digit entry window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p10 <= BLANK_CODE;
         p11 <= BLANK_CODE;
         p12 <= BLANK_CODE;
         p13 <= BLANK_CODE;
      end else if (valid_c) begin
         p13 <= p12;
         p12 <= p11;
         p11 <= p10;
         p10 <= digit_c;
      end
   end

endmodule

// File: tb/tb_keypad_digit_entry.sv
module tb_keypad_digit_entry;

   localparam int unsigned LAT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] keys;
   logic [3:0] p10, p11, p12, p13;

   int total  = 0;
   int passed = 0;

   // Reference model: every vector sampled by a clock edge, and the digits entered so far
   logic [9:0] samp_q[$];
   int         digits_q[$];

   always #5 clk = ~clk;

   keypad_digit_entry #(.SYNC_STAGES(LAT), .BLANK_CODE(4'hF)) dut (
      .clk(clk), .rst(rst),
      .Input0(keys[0]), .Input1(keys[1]), .Input2(keys[2]), .Input3(keys[3]),
      .Input4(keys[4]), .Input5(keys[5]), .Input6(keys[6]), .Input7(keys[7]),
      .Input8(keys[8]), .Input9(keys[9]),
      .p10(p10), .p11(p11), .p12(p12), .p13(p13)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic int nkeys(input logic [9:0] v);
      int n = 0;
      for (int i = 0; i < 10; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic logic [3:0] model_pos(input int age);
      if (digits_q.size() > age) return 4'(digits_q[digits_q.size()-1-age]);
      return 4'hF;
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".p10"}, p10, model_pos(0));
      check({tag, ".p11"}, p11, model_pos(1));
      check({tag, ".p12"}, p12, model_pos(2));
      check({tag, ".p13"}, p13, model_pos(3));
   endtask

   task automatic model_reset();
      samp_q.delete();
      digits_q.delete();
      for (int i = 0; i <= int'(LAT); i++) samp_q.push_back(10'd0);
   endtask

   // Drive k for one clock edge (called at negedge), advance model, check at next negedge
   task automatic cyc(input logic [9:0] k, input string tag);
      logic [9:0] now_v, before_v;
      keys = k;
      @(posedge clk);
      samp_q.push_back(k);
      now_v    = samp_q[samp_q.size()-1-LAT];
      before_v = samp_q[samp_q.size()-2-LAT];
      // Key pressed now that was up before, and it is the only key down
      if (nkeys(now_v) == 1 && nkeys(now_v & ~before_v) == 1) begin
         for (int i = 0; i < 10; i++) if (now_v[i]) digits_q.push_back(i);
      end
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(10'd0, tag);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         keys = 10'($urandom);
         @(negedge clk);
         check("rst.p10", p10, 4'hF);
         check("rst.p11", p11, 4'hF);
         check("rst.p12", p12, 4'hF);
         check("rst.p13", p13, 4'hF);
      end
      keys = 10'd0;
      rst  = 1'b1;
      model_reset();
   endtask

   task automatic check_const(input string tag, input logic [3:0] e13, input logic [3:0] e12,
                              input logic [3:0] e11, input logic [3:0] e10);
      check({tag, ".p13"}, p13, e13);
      check({tag, ".p12"}, p12, e12);
      check({tag, ".p11"}, p11, e11);
      check({tag, ".p10"}, p10, e10);
   endtask

   function automatic logic [9:0] rand_keys(input logic [9:0] last);
      int unsigned r = $urandom_range(0, 9);
      if (r < 3) return 10'd0;
      if (r < 5) return last;
      if (r < 8) return 10'(1 << $urandom_range(0, 9));
      return 10'($urandom);
   endfunction

   initial begin
      logic [9:0] rk;
      rst  = 1'b0;
      keys = 10'd0;
      @(negedge clk);
      do_reset();

      // Back-to-back single-cycle presses
      cyc(10'b1 << 1, "seq"); cyc(10'b1 << 2, "seq");
      cyc(10'b1 << 3, "seq"); cyc(10'b1 << 4, "seq");
      idle(3, "seq");
      check_const("seq_final", 4'd1, 4'd2, 4'd3, 4'd4);

      // Sliding window
      cyc(10'b1 << 5, "win"); cyc(10'b1 << 6, "win");
      cyc(10'b1 << 7, "win"); cyc(10'b1 << 8, "win");
      idle(3, "win");
      check_const("win_final", 4'd5, 4'd6, 4'd7, 4'd8);

      // Held key counted once
      do_reset();
      for (int i = 0; i < 10; i++) cyc(10'b1 << 7, "held");
      idle(3, "held");
      check_const("held_final", 4'hF, 4'hF, 4'hF, 4'd7);

      // Simultaneous edges and edge while another key is held
      for (int i = 0; i < 3; i++) cyc((10'b1 << 3) | (10'b1 << 9), "simul");
      for (int i = 0; i < 3; i++) cyc((10'b1 << 3) | (10'b1 << 5), "overlap");
      idle(3, "release");
      check_const("simul_none", 4'hF, 4'hF, 4'hF, 4'd7);
      cyc(10'b1 << 0, "zero");
      idle(3, "zero");
      check_const("zero_final", 4'hF, 4'hF, 4'd7, 4'd0);

      // Partial entry
      do_reset();
      cyc(10'b1 << 9, "part"); cyc(10'b1 << 0, "part");
      idle(3, "part");
      check_const("part_final", 4'hF, 4'hF, 4'd9, 4'd0);

      // Randomised activity against the model
      rk = 10'd0;
      for (int i = 0; i < 300; i++) begin
         rk = rand_keys(rk);
         cyc(rk, "rand");
      end

      // Asynchronous reset mid-sequence, away from any clock edge
      cyc(10'b1 << 2, "pre_async");
      cyc(10'b1 << 6, "pre_async");
      idle(3, "pre_async");
      #2 rst = 1'b0;
      #1 check_const("async_rst", 4'hF, 4'hF, 4'hF, 4'hF);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 200; i++) begin
         rk = rand_keys(rk);
         cyc(rk, "rand2");
      end
      idle(3, "tail");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
- Front end of the FPGA door lock keypad: ten active-high key inputs (digits 0-9) are synchronised, edge-detected and encoded to BCD.
- Each valid key press shifts one digit into a 4-digit entry register.
- The four register digits drive the 7-segment display / password compare stage.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages per key input; legal range 1-3.
- BLANK_CODE, 4'hF, code held in a digit position that has no entered digit (display blank).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- Input0 .. Input9  input  1 each  key n pressed when high; asynchronous to clk; no debounce required.
- p10  output  4  most recently entered digit, BCD.
- p11  output  4  second most recent digit.
- p12  output  4  third most recent digit.
- p13  output  4  oldest (fourth most recent) digit.

Behaviour:
- Reset (rst low, asynchronous): p10..p13 = BLANK_CODE; all synchroniser stages and the previous-sample register clear to 0. Reset takes effect immediately regardless of clk. First update is possible on the first clk rising edge after rst goes high.
- Key vector: K[9:0] = {Input9..Input0}.
- Synchronisation: K passes through SYNC_STAGES flops, giving S. A register P holds S delayed by one clock.
- Rising-edge vector: R = S & ~P. Detection is per key, so a direct switch from one key to another with no idle cycle is a new press.
- Valid press: R has exactly one bit set AND S has exactly one bit set. The digit value is the index of that bit (0-9).
- On a valid press at a rising edge: p13<=p12, p12<=p11, p11<=p10, p10<=digit.
- All other cycles: p10..p13 hold their values. This covers:
  - no press;
  - a key held high over multiple cycles (counted once only);
  - two or more simultaneous rising edges;
  - a rising edge while another key is still held.
- Latency: the key level is sampled at edge N. With SYNC_STAGES=2, S updates at N+1 and the outputs change at edge N+2. In general the shift occurs at edge N+SYNC_STAGES.
- A key high for only one sampling edge is still registered.
- Wrap-around: a fifth and later digit discards the oldest digit (sliding window); there is no counter saturation.
- Outputs are registered directly, with no combinational path from the inputs.
- Blank positions read BLANK_CODE until enough digits have been entered.

Test Plan:
- Reset: hold rst low for 2 cycles with key activity -> p10..p13 = F,F,F,F throughout. Assert rst low mid-sequence -> all outputs F asynchronously.
- Sequential entry: press 1, 2, 3, 4, each high for exactly one clock period, back-to-back with no gap -> p13..p10 = 1,2,3,4. Each digit appears 2 edges after sampling (SYNC_STAGES=2).
- Sliding window: after the above, idle 3 cycles, then press 5, 6, 7, 8 -> p13..p10 = 5,6,7,8.
- Held key: hold Input7 high for 10 cycles from reset -> p10=7, p11..p13 = F. Only one entry.
- Simultaneous keys: raise Input3 and Input9 on the same cycle -> no change. Then, while Input3 is still held, raise Input5 -> no change. Release all, then press 0 -> p10=0.
- Partial entry: after reset, press 9 then 0 -> p10=0, p11=9, p12=F, p13=F.
